// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and payload layout for the pipeline skid register
package pipe_pkg;

    localparam int RD_W_DEF   = 5;
    localparam int DATA_W_DEF = 32;

    // Field order matches the flat {we, rd, data} vector held in each slot.
    typedef struct packed {
        logic                  we;
        logic [RD_W_DEF-1:0]   rd;
        logic [DATA_W_DEF-1:0] data;
    } pipe_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid bit plus payload register with load, drop and clear
module pipe_slot #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] load_val,
    output logic         valid,
    output logic [W-1:0] pay
);

    logic         valid_q, valid_d;
    logic [W-1:0] pay_q, pay_d;

    // clear beats load beats drop; drop keeps the stale payload to avoid a mux
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (clr) begin
            valid_d = 1'b0;
            pay_d   = RST_VAL;
        end else if (load) begin
            valid_d = 1'b1;
            pay_d   = load_val;
        end else if (drop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid = valid_q;
    assign pay   = pay_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register; PIPE_SKID_EN adds a skid entry for a registered in_ready
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                RD_W     = RD_W_DEF,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int                PAY_W   = 1 + RD_W + DATA_W;
    localparam logic [PAY_W-1:0] PAY_RST = {1'b0, {RD_W{1'b0}}, RST_DATA};

    logic [PAY_W-1:0] in_pay;
    logic             head_valid;
    logic [PAY_W-1:0] head_pay;
    logic [PAY_W-1:0] head_load_val;
    logic             head_load, head_drop;
    logic             accept, retire;

    assign in_pay = {in_we, in_rd, in_data};
    assign accept = in_valid && in_ready && !flush;
    assign retire = head_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic             skid_valid;
    logic [PAY_W-1:0] skid_pay;
    logic             skid_load, skid_drop;

    // skid only fills while the head stalls, so it is always the younger entry
    always_comb begin
        head_load     = 1'b0;
        head_drop     = 1'b0;
        head_load_val = in_pay;
        skid_load     = 1'b0;
        skid_drop     = 1'b0;
        if (skid_valid) begin
            head_load_val = skid_pay;
            head_load     = retire;
            skid_drop     = retire;
        end else begin
            head_load = accept && (!head_valid || retire);
            head_drop = retire && !accept;
            skid_load = accept && head_valid && !retire;
        end
    end

    pipe_slot #(
        .W       (PAY_W),
        .RST_VAL (PAY_RST)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (skid_load),
        .drop     (skid_drop),
        .load_val (in_pay),
        .valid    (skid_valid),
        .pay      (skid_pay)
    );

    assign in_ready  = !skid_valid;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};
`else
    always_comb begin
        head_load     = accept;
        head_drop     = retire && !accept;
        head_load_val = in_pay;
    end

    assign in_ready  = !head_valid || out_ready;
    assign occupancy = {1'b0, head_valid};
`endif

    pipe_slot #(
        .W       (PAY_W),
        .RST_VAL (PAY_RST)
    ) u_head (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .load     (head_load),
        .drop     (head_drop),
        .load_val (head_load_val),
        .valid    (head_valid),
        .pay      (head_pay)
    );

    // writes to x0 never reach the register file
    assign out_valid = head_valid;
    assign out_data  = head_pay[DATA_W-1:0];
    assign out_rd    = head_pay[DATA_W +: RD_W];
    assign out_we    = head_pay[PAY_W-1] && head_valid && (out_rd != '0);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and streamed checks of pipe_skid_reg
module tb_pipe_skid_reg;
    import pipe_pkg::*;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_we, out_valid, out_ready, out_we;
    logic [4:0]  in_rd, out_rd;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_we    (out_we),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_we"},    out_we,    0);
        chk({tag, "_rd"},    out_rd,    0);
        chk({tag, "_data"},  out_data,  0);
        chk({tag, "_occ"},   occupancy, 0);
        chk({tag, "_rdy"},   in_ready,  1);
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
        in_valid = v;
        in_we    = we;
        in_rd    = rd;
        in_data  = d;
    endtask

    // Leaves out_ready low with A held and, in the skid build, B in the skid slot.
    task automatic fill_two();
        out_ready = 1'b0;
        drive(1, 1, 5'd3, 32'hAAAA);
        tick();
        drive(1, 1, 5'd4, 32'hBBBB);
        tick();
        chk("fill_occ", occupancy, SKID ? 2 : 1);
    endtask

    initial begin
        pipe_payload_t exp_q[$];
        pipe_payload_t cur, hd;
        int            sent, got, cyc;
        bit            fin, fout;

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // basic one-cycle transfer
        out_ready = 1'b1;
        drive(1, 1, 5'd5, 32'h1234);
        tick();
        chk("xfer_valid", out_valid, 1);
        chk("xfer_we",    out_we,    1);
        chk("xfer_rd",    out_rd,    5);
        chk("xfer_data",  out_data,  32'h1234);
        chk("xfer_occ",   occupancy, 1);

        // x0 write suppressed; head replaced while retiring
        drive(1, 1, 5'd0, 32'hBEEF);
        tick();
        chk("x0_valid", out_valid, 1);
        chk("x0_we",    out_we,    0);
        chk("x0_data",  out_data,  32'hBEEF);
        chk("x0_occ",   occupancy, 1);

        drive(0, 0, 0, 0);
        tick();
        chk("drain_valid", out_valid, 0);
        chk("drain_occ",   occupancy, 0);

        // stall: A held, B offered
        out_ready = 1'b0;
        drive(1, 1, 5'd3, 32'hAAAA);
        tick();
        chk("stallA_valid", out_valid, 1);
        chk("stallA_data",  out_data,  32'hAAAA);
        chk("stallA_rdy",   in_ready,  SKID ? 1 : 0);
        drive(1, 1, 5'd4, 32'hBBBB);
        tick();
        chk("stallB_occ",  occupancy, SKID ? 2 : 1);
        chk("stallB_rdy",  in_ready,  0);
        chk("stallB_data", out_data,  32'hAAAA);
        chk("stallB_rd",   out_rd,    3);
        chk("stallB_we",   out_we,    1);
        drive(0, 0, 0, 0);
        out_ready = 1'b1;
        tick();
        chk("relA_valid", out_valid, SKID ? 1 : 0);
        chk("relA_occ",   occupancy, SKID ? 1 : 0);
        chk("relA_rdy",   in_ready,  1);
        if (SKID) begin
            chk("relB_data", out_data, 32'hBBBB);
            chk("relB_rd",   out_rd,   4);
        end
        tick();
        chk("relB_valid", out_valid, 0);
        chk("relB_occ",   occupancy, 0);

        // flush with a same-cycle input
        fill_two();
        flush = 1'b1;
        drive(1, 1, 5'd7, 32'hCCCC);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0);
        chk_reset_state("flush");
        tick();
        chk("flush_drop_valid", out_valid, 0);
        chk("flush_drop_occ",   occupancy, 0);

        // reset while full
        fill_two();
        rst = 1'b1;
        drive(1, 1, 5'd9, 32'hDDDD);
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        chk_reset_state("rst_full");

        // random stream of 100 entries against a FIFO scoreboard
        sent = 0;
        got  = 0;
        cyc  = 0;
        cur  = pipe_payload_t'({$urandom_range(1), 5'($urandom_range(31)), 32'($urandom)});
        while (got < 100 && cyc < 3000) begin
            in_valid  = (sent < 100) && ($urandom_range(3) != 0);
            in_we     = cur.we;
            in_rd     = cur.rd;
            in_data   = cur.data;
            out_ready = ($urandom_range(2) != 0);
            #1;
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fout) begin
                got++;
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", out_valid, 0);
                end else begin
                    hd = exp_q.pop_front();
                    chk("stream_rd",   out_rd,   hd.rd);
                    chk("stream_data", out_data, hd.data);
                    chk("stream_we",   out_we,   hd.we && (hd.rd != 0));
                end
            end
            if (fin) begin
                exp_q.push_back(cur);
                sent++;
                cur = pipe_payload_t'({$urandom_range(1), 5'($urandom_range(31)), 32'($urandom)});
            end
            tick();
            cyc++;
        end
        chk("stream_count", got, 100);
        chk("stream_left",  exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
